// File: rtl/condlogic_pkg.sv
// Shared definitions for the conditional-execution stage: condition-code
// encodings and bit positions inside the {N,Z,C,V} flag word.
package condlogic_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/condlogic_condcheck.sv
// Purely combinational condition evaluator: condition field x {N,Z,C,V}.
// Kept free of state so other units (e.g. a branch predictor) can reuse it.
module condcheck
    import condlogic_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    logic ge;

    assign n  = flags[FLAG_N];
    assign z  = flags[FLAG_Z];
    assign c  = flags[FLAG_C];
    assign v  = flags[FLAG_V];
    assign ge = (n == v);

    // Decode the condition field against the current flags.
    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = ~ge;
            COND_GT: cond_ex = ~z & ge;
            COND_LE: cond_ex = z | ~ge;
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b1;   // no "never" encoding; behaves as AL
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution and flag-storage stage. Holds NZCV, evaluates the
// instruction condition, and turns raw decoder write requests into the
// qualified enables for the datapath. The verdict is registered once at
// execute so later write-back states reuse it while Cond is held stable.
module condlogic
    import condlogic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       FPUW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       FPUWrite,
    output logic [3:0] Flags,
    output logic       CondExR
);

    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic       cond_ex;
    logic       cond_ex_q;
    logic [1:0] flag_write;

    assign Flags = {nz_q, cv_q};

    condcheck u_condcheck (
        .cond    (Cond),
        .flags   (Flags),
        .cond_ex (cond_ex)
    );

    // Unregistered verdict gates flag writes so a failing instruction
    // can never disturb the flags it was tested against.
    assign flag_write = FlagW & {2{cond_ex}};

    // N,Z half of the flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            nz_q <= 2'b00;
        else if (flag_write[1])
            nz_q <= ALUFlags[FLAG_N:FLAG_Z];
    end

    // C,V half of the flag register, independent of the N,Z half.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cv_q <= 2'b00;
        else if (flag_write[0])
            cv_q <= ALUFlags[FLAG_C:FLAG_V];
    end

    // Condition verdict captured every cycle; uses pre-write flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cond_ex_q <= 1'b0;
        else
            cond_ex_q <= cond_ex;
    end

    assign CondExR = cond_ex_q;

    // Qualified enables; reset squashes them at once through cond_ex_q.
    // NextPC bypasses the condition so fetch always advances.
    assign RegWrite = RegW & cond_ex_q;
    assign MemWrite = MemW & cond_ex_q;
    assign FPUWrite = FPUW & cond_ex_q;
    assign PCWrite  = (PCS & cond_ex_q) | NextPC;

endmodule

// File: tb/tb_condlogic.sv
// Self-checking bench for condlogic: a behavioural flag/condition model
// checked every negative edge, plus directed literal checks.
module tb_condlogic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW, FPUW;
    logic       PCWrite, RegWrite, MemWrite, FPUWrite;
    logic [3:0] Flags;
    logic       CondExR;

    int total = 0;
    int bad   = 0;

    condlogic dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .FPUW     (FPUW),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .FPUWrite (FPUWrite),
        .Flags    (Flags),
        .CondExR  (CondExR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Condition semantics from the architectural rules: even codes test a
    // base predicate, odd codes test its inverse, except the 111x pair.
    function automatic logic model_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cc[0] && cc[3:1] != 3'd7) return !base;
        return base;
    endfunction

    logic [3:0] m_flags;
    logic       m_cexr;

    // Reference state update.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_flags <= 4'b0000;
            m_cexr  <= 1'b0;
        end else begin
            logic ce;
            ce = model_cond(Cond, m_flags);
            m_cexr <= ce;
            if (ce && FlagW[1]) m_flags[3:2] <= ALUFlags[3:2];
            if (ce && FlagW[0]) m_flags[1:0] <= ALUFlags[1:0];
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        check("model_flags",   Flags,    m_flags);
        check("model_condexr", {3'b0, CondExR},  {3'b0, m_cexr});
        check("model_regw",    {3'b0, RegWrite}, {3'b0, RegW & m_cexr});
        check("model_memw",    {3'b0, MemWrite}, {3'b0, MemW & m_cexr});
        check("model_fpuw",    {3'b0, FPUWrite}, {3'b0, FPUW & m_cexr});
        check("model_pcw",     {3'b0, PCWrite},  {3'b0, (PCS & m_cexr) | NextPC});
    end

    task automatic drive(input logic [3:0] cc, input logic [3:0] af, input logic [1:0] fw,
                         input logic pcs, input logic npc, input logic rw,
                         input logic mw, input logic fw_u);
        Cond = cc; ALUFlags = af; FlagW = fw;
        PCS = pcs; NextPC = npc; RegW = rw; MemW = mw; FPUW = fw_u;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        drive(4'b1110, f, 2'b11, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        drive(4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        check("post_reset_flags", Flags, 4'b0000);

        // Reset squashes pending writes immediately.
        set_flags(4'b1111);
        drive(4'b1110, 4'b0000, 2'b00, 1, 0, 1, 1, 1);
        tick();
        check("pre_reset_regw", {3'b0, RegWrite}, 4'b0001);
        #2 reset = 1'b0;
        #1;
        check("rst_flags", Flags, 4'b0000);
        check("rst_enables", {PCWrite, RegWrite, MemWrite, FPUWrite}, 4'b0000);
        check("rst_condexr", {3'b0, CondExR}, 4'b0000);
        #10 reset = 1'b1;
        tick();

        // EQ gating.
        set_flags(4'b0100);
        drive(4'b0000, 4'b0000, 2'b00, 0, 0, 1, 1, 0);
        tick();
        check("eq_pass_regw", {3'b0, RegWrite}, 4'b0001);
        set_flags(4'b0000);
        drive(4'b0000, 4'b0000, 2'b00, 0, 0, 1, 1, 0);
        tick();
        check("eq_fail_regw", {3'b0, RegWrite}, 4'b0000);
        check("eq_fail_memw", {3'b0, MemWrite}, 4'b0000);

        // Partial flag writes.
        drive(4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0, 0);
        tick();
        check("partial_nz", Flags, 4'b1100);
        drive(4'b1110, 4'b0000, 2'b01, 0, 0, 0, 0, 0);
        tick();
        check("partial_cv", Flags, 4'b1100);

        // Failing condition must not write flags.
        set_flags(4'b0000);
        drive(4'b0000, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
        tick();
        check("fail_blocks_flags", Flags, 4'b0000);

        // Signed compares.
        set_flags(4'b1001);
        drive(4'b1010, 0, 0, 0, 0, 0, 0, 0); tick(); check("ge_1001", {3'b0, CondExR}, 4'b0001);
        drive(4'b1100, 0, 0, 0, 0, 0, 0, 0); tick(); check("gt_1001", {3'b0, CondExR}, 4'b0001);
        drive(4'b1011, 0, 0, 0, 0, 0, 0, 0); tick(); check("lt_1001", {3'b0, CondExR}, 4'b0000);
        drive(4'b1101, 0, 0, 0, 0, 0, 0, 0); tick(); check("le_1001", {3'b0, CondExR}, 4'b0000);
        set_flags(4'b1101);
        drive(4'b1100, 0, 0, 0, 0, 0, 0, 0); tick(); check("gt_1101", {3'b0, CondExR}, 4'b0000);
        drive(4'b1101, 0, 0, 0, 0, 0, 0, 0); tick(); check("le_1101", {3'b0, CondExR}, 4'b0001);
        set_flags(4'b0010);
        drive(4'b1000, 0, 0, 0, 0, 0, 0, 0); tick(); check("hi_0010", {3'b0, CondExR}, 4'b0001);
        drive(4'b1001, 0, 0, 0, 0, 0, 0, 0); tick(); check("ls_0010", {3'b0, CondExR}, 4'b0000);

        // PC path.
        set_flags(4'b0000);
        drive(4'b0000, 0, 0, 0, 1, 0, 0, 0);
        tick();
        check("nextpc_bypass", {3'b0, PCWrite}, 4'b0001);
        drive(4'b0000, 0, 0, 1, 0, 0, 0, 0);
        tick();
        check("pcs_fail", {3'b0, PCWrite}, 4'b0000);
        drive(4'b1110, 0, 0, 1, 0, 0, 0, 0);
        #1;
        check("pcs_al_before_edge", {3'b0, PCWrite}, 4'b0000);
        tick();
        check("pcs_al_after_edge", {3'b0, PCWrite}, 4'b0001);

        // Simultaneous flag write and evaluation: CondExR uses old flags.
        set_flags(4'b0000);
        drive(4'b0001, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
        tick();
        check("same_cycle_flags", Flags, 4'b0100);
        check("same_cycle_condexr", {3'b0, CondExR}, 4'b0001);

        // Sweep every condition against every flag value, model-checked.
        for (int f = 0; f < 16; f++) begin
            set_flags(f[3:0]);
            for (int cc = 0; cc < 16; cc++) begin
                drive(cc[3:0], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
                tick();
                set_flags(f[3:0]);
            end
        end

        drive(4'b1110, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
